// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

    // Arbiter FSM encoding: free arbitration vs. burst held by one owner
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Ceiling log2, used to size pointers and counters (v >= 2)
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: first set request at or after start index.
// Latency: purely combinational.
// Backpressure: none; grant falls back to start index when nothing is set.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   start_i,
    output logic [IW-1:0]   gnt_o,
    output logic            any_o
);

    logic [IW-1:0] idx_w;

    // Scan from the farthest offset down so the nearest requester wins last
    always_comb begin
        gnt_o = start_i;
        any_o = 1'b0;
        idx_w = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_w = IW'((int'(start_i) + k) % NREQ);
            if (req_i[idx_w]) begin
                gnt_o = idx_w;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, bursts locked to one producer.
// Latency: zero-cycle combinational accept; grant changes visible next cycle.
// Backpressure: fifo_full blocks the accept in the same cycle; all state holds.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 16,
    parameter int MAX_BURST = 4,
    localparam int IW = clog2(NREQ),
    localparam int BW = clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DWIDTH-1:0]        fifo_din,
    output logic [IW-1:0]            gnt_id,
    output logic                     locked
);

    arb_state_e    state_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] owner_q;
    logic [BW-1:0] beat_cnt_q;
    logic [BW-1:0] beat_cnt_d;
    logic          locked_q;

    logic [IW-1:0] pick_gnt;
    logic          pick_any;
    logic [IW-1:0] gnt;
    logic          gnt_vld;
    logic          accept;
    logic          last_beat;
    logic [IW-1:0] ptr_after;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (req_valid),
        .start_i (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .any_o   (pick_any)
    );

    // Grant: owner while locked, otherwise the round-robin pick
    always_comb begin
        gnt        = (state_q == ST_LOCK) ? owner_q : pick_gnt;
        gnt_vld    = (state_q == ST_LOCK) ? req_valid[owner_q] : pick_any;
        // rstn gating keeps the write port quiet for the whole reset window
        accept     = rstn & gnt_vld & ~fifo_full;
        last_beat  = req_last[gnt];
        ptr_after  = (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
        beat_cnt_d = beat_cnt_q + BW'(1);
        req_ready  = accept ? (NREQ'(1) << gnt) : '0;
        fifo_wr_en = accept;
        fifo_din   = req_data[gnt*DWIDTH +: DWIDTH];
        gnt_id     = rstn ? gnt : '0;
        locked     = locked_q;
    end

    // Arbitration FSM: lock on multi-beat bursts, release on last or beat cap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (last_beat || (MAX_BURST == 1)) begin
                        rr_ptr_q <= ptr_after;
                    end else begin
                        state_q    <= ST_LOCK;
                        locked_q   <= 1'b1;
                        owner_q    <= gnt;
                        beat_cnt_q <= BW'(1);
                    end
                end
                ST_LOCK: begin
                    if (last_beat || (beat_cnt_d == BW'(MAX_BURST))) begin
                        state_q    <= ST_IDLE;
                        locked_q   <= 1'b0;
                        rr_ptr_q   <= ptr_after;
                        beat_cnt_q <= '0;
                    end else begin
                        beat_cnt_q <= beat_cnt_d;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed bursts, scoreboard on the FIFO write port.
// Latency: expects writes in the same cycle as the offered beat.
// Backpressure: models an 8-deep FIFO to drive fifo_full.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic [1:0]  gnt_id;
    logic        locked;

    int          checks;
    int          errors;
    logic [15:0] exp_q[$];

    int          fifo_cnt;
    logic        pop;
    logic        flush;

    fifo_wr_arbiter #(.NREQ(4), .DWIDTH(16), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .gnt_id     (gnt_id),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy model of the 8-deep Sync_FIFO behind the arbiter
    assign fifo_full = (fifo_cnt >= 8);
    always @(posedge clk) begin
        if (flush) fifo_cnt <= 0;
        else       fifo_cnt <= fifo_cnt + (fifo_wr_en ? 1 : 0) - (pop ? 1 : 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_dat(input int i, input logic [15:0] v);
        req_data[i*16 +: 16] = v;
    endtask

    // One cycle of stimulus; expected write (if any) goes to the scoreboard
    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic exp_wr,
                       input logic [15:0] exp_dat, input logic exp_lock, input logic [1:0] exp_gnt);
        logic [3:0] exp_rdy;
        req_valid = v;
        req_last  = l;
        if (exp_wr) exp_q.push_back(exp_dat);
        exp_rdy = exp_wr ? (4'b0001 << exp_gnt) : 4'b0000;
        #4;
        chk("wr_en",     32'(fifo_wr_en), 32'(exp_wr));
        chk("req_ready", 32'(req_ready),  32'(exp_rdy));
        chk("locked",    32'(locked),     32'(exp_lock));
        chk("gnt_id",    32'(gnt_id),     32'(exp_gnt));
        @(posedge clk);
        #1;
    endtask

    // Reset with all requests asserted; outputs must be quiet immediately
    task automatic do_reset();
        rstn      = 1'b0;
        flush     = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #4;
        chk("rst_locked", 32'(locked),     32'd0);
        chk("rst_gnt_id", 32'(gnt_id),     32'd0);
        chk("rst_ready",  32'(req_ready),  32'd0);
        chk("rst_wr_en",  32'(fifo_wr_en), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn      = 1'b1;
        flush     = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;

        // Scoreboard monitor: every write must match the next expected beat
        fork
            forever begin
                logic [15:0] e;
                @(negedge clk);
                if (fifo_wr_en) begin
                    chk("no_write_while_full", 32'(fifo_full), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %0h expected none at %0t", fifo_din, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("fifo_din", 32'(fifo_din), 32'(e));
                    end
                end
            end
        join_none

        @(posedge clk); #1;
        do_reset();

        // 1: single beats rotate 0,1,2,3,0 with no lock
        for (int i = 0; i < 4; i++) set_dat(i, 16'(16'h0A00 + i));
        cyc(4'b1111, 4'b1111, 1'b1, 16'h0A00, 1'b0, 2'd0);
        cyc(4'b1111, 4'b1111, 1'b1, 16'h0A01, 1'b0, 2'd1);
        cyc(4'b1111, 4'b1111, 1'b1, 16'h0A02, 1'b0, 2'd2);
        cyc(4'b1111, 4'b1111, 1'b1, 16'h0A03, 1'b0, 2'd3);
        cyc(4'b1111, 4'b1111, 1'b1, 16'h0A00, 1'b0, 2'd0);
        do_reset();

        // 2: 3-beat burst from req0 locks out req1; rr_ptr moves to 1
        set_dat(1, 16'h0B01);
        set_dat(0, 16'h0011); cyc(4'b0011, 4'b0010, 1'b1, 16'h0011, 1'b0, 2'd0);
        set_dat(0, 16'h0022); cyc(4'b0011, 4'b0010, 1'b1, 16'h0022, 1'b1, 2'd0);
        set_dat(0, 16'h0033); cyc(4'b0011, 4'b0011, 1'b1, 16'h0033, 1'b1, 2'd0);
        set_dat(0, 16'h0044); cyc(4'b0011, 4'b0011, 1'b1, 16'h0B01, 1'b0, 2'd1);
        do_reset();

        // 3: 6-beat burst from req2 is cut after 4 beats, req3 slips in
        set_dat(3, 16'h0D03);
        for (int b = 1; b <= 4; b++) begin
            set_dat(2, 16'(16'h0200 + b));
            cyc(4'b1100, 4'b1000, 1'b1, 16'(16'h0200 + b), (b > 1), 2'd2);
        end
        set_dat(2, 16'h0205); cyc(4'b1100, 4'b1000, 1'b1, 16'h0D03, 1'b0, 2'd3);
        cyc(4'b0100, 4'b0000, 1'b1, 16'h0205, 1'b0, 2'd2);
        set_dat(2, 16'h0206); cyc(4'b0100, 4'b0100, 1'b1, 16'h0206, 1'b1, 2'd2);
        do_reset();

        // 4: fill FIFO, then full blocks req1/req2 without moving rr_ptr
        set_dat(3, 16'h0E03);
        repeat (8) cyc(4'b1000, 4'b1000, 1'b1, 16'h0E03, 1'b0, 2'd3);
        set_dat(1, 16'h0B11);
        set_dat(2, 16'h0C22);
        cyc(4'b0110, 4'b0110, 1'b0, 16'h0000, 1'b0, 2'd1);
        cyc(4'b0110, 4'b0110, 1'b0, 16'h0000, 1'b0, 2'd1);
        pop = 1'b1;
        cyc(4'b0110, 4'b0110, 1'b0, 16'h0000, 1'b0, 2'd1);
        pop = 1'b0;
        cyc(4'b0110, 4'b0110, 1'b1, 16'h0B11, 1'b0, 2'd1);
        cyc(4'b0110, 4'b0110, 1'b0, 16'h0000, 1'b0, 2'd2);
        do_reset();

        // 5: owner stall keeps lock, then reset aborts the burst
        set_dat(0, 16'h0501);
        set_dat(1, 16'h0B21);
        cyc(4'b0011, 4'b0010, 1'b1, 16'h0501, 1'b0, 2'd0);
        cyc(4'b0010, 4'b0010, 1'b0, 16'h0000, 1'b1, 2'd0);
        cyc(4'b0010, 4'b0010, 1'b0, 16'h0000, 1'b1, 2'd0);
        set_dat(0, 16'h0502);
        cyc(4'b0011, 4'b0010, 1'b1, 16'h0502, 1'b1, 2'd0);
        do_reset();
        set_dat(3, 16'h0D23);
        cyc(4'b1010, 4'b1010, 1'b1, 16'h0B21, 1'b0, 2'd1);
        cyc(4'b1010, 4'b1010, 1'b1, 16'h0D23, 1'b0, 2'd3);
        cyc(4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so a stuck run still terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
